// File: rtl/branch_predictor_if.sv
// Bundle between the fetch/execute pipeline and the branch predictor:
// lookup on the fetch side, resolve/update and misprediction flags on the EX side.
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_next_pc;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_is_branch;
    logic        upd_is_jump;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_next_pc, mispredict, redirect_pc,
               branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_is_branch, upd_is_jump, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken, pred_next_pc, mispredict, redirect_pc,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency lookup for IF,
// single-cycle update and misprediction detection from the EX-stage resolve.
module branch_predictor #(
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
    input  logic clk,
    input  logic reset,
    branch_predictor_if.slave bus
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    logic                  valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [31:0]           target_q [ENTRIES];
    logic [1:0]            ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  lk_hit;
    logic [INDEX_BITS-1:0] up_idx;
    logic [TAG_BITS-1:0]   up_tag;
    logic                  up_hit;
    logic                  is_ctrl;
    logic                  actual_taken;
    logic                  unused_pc_bits;

    assign unused_pc_bits = ^{bus.if_pc[1:0], bus.upd_pc[1:0]};

    assign lk_idx = bus.if_pc[INDEX_BITS+1:2];
    assign lk_tag = bus.if_pc[31:INDEX_BITS+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign bus.pred_taken   = lk_hit && ctr_q[lk_idx][1];
    assign bus.pred_next_pc = bus.pred_taken ? target_q[lk_idx] : bus.if_pc + 32'd4;

    assign up_idx       = bus.upd_pc[INDEX_BITS+1:2];
    assign up_tag       = bus.upd_pc[31:INDEX_BITS+2];
    assign up_hit       = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign is_ctrl      = bus.upd_is_branch || bus.upd_is_jump;
    assign actual_taken = bus.upd_is_jump || (bus.upd_is_branch && bus.upd_taken);

    // A non-control instruction is "actually not taken", so an aliased
    // prediction of taken falls out of the same comparison.
    assign bus.mispredict  = bus.upd_valid &&
                             ((bus.upd_pred_taken != actual_taken) ||
                              (actual_taken && (bus.upd_pred_target != bus.upd_target)));
    assign bus.redirect_pc = actual_taken ? bus.upd_target : bus.upd_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'd1;
            end
        end else if (bus.upd_valid) begin
            if (is_ctrl) begin
                if (up_hit) begin
                    if (bus.upd_is_jump)
                        ctr_q[up_idx] <= 2'd3;
                    else if (bus.upd_taken && ctr_q[up_idx] != 2'd3)
                        ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
                    else if (!bus.upd_taken && ctr_q[up_idx] != 2'd0)
                        ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
                end else if (actual_taken) begin
                    valid_q[up_idx] <= 1'b1;
                    ctr_q[up_idx]   <= bus.upd_is_jump ? 2'd3 : 2'd2;
                end
            end else if (up_hit) begin
                valid_q[up_idx] <= 1'b0;
            end
        end
    end

    // Tag is rewritten even on a hit (same value), which keeps allocate and
    // target refresh on one enable.
    always_ff @(posedge clk) begin
        if (!reset && bus.upd_valid && is_ctrl && actual_taken) begin
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= bus.upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.branch_count     <= 32'd0;
            bus.mispredict_count <= 32'd0;
        end else begin
            if (bus.upd_valid && is_ctrl)
                bus.branch_count <= bus.branch_count + 32'd1;
            if (bus.mispredict)
                bus.mispredict_count <= bus.mispredict_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed scoreboard bench for branch_predictor: expectations are queued as
// stimulus is applied and popped against the DUT outputs.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predictor_if bus();
    branch_predictor #(.INDEX_BITS(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    int          checks = 0;
    int          errors = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic push(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %h expected none", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", t, obs, e);
        end
    endtask

    task automatic idle();
        bus.upd_valid       = 1'b0;
        bus.upd_pc          = 32'h0;
        bus.upd_is_branch   = 1'b0;
        bus.upd_is_jump     = 1'b0;
        bus.upd_taken       = 1'b0;
        bus.upd_target      = 32'h0;
        bus.upd_pred_taken  = 1'b0;
        bus.upd_pred_target = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic resolve(input logic [31:0] pc, input logic br, input logic jmp,
                           input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        bus.upd_valid       = 1'b1;
        bus.upd_pc          = pc;
        bus.upd_is_branch   = br;
        bus.upd_is_jump     = jmp;
        bus.upd_taken       = tk;
        bus.upd_target      = tgt;
        bus.upd_pred_taken  = ptk;
        bus.upd_pred_target = ptgt;
    endtask

    task automatic mp_check(input string t, input logic mp, input logic [31:0] redir);
        push({t, "_mispredict"}, {31'd0, mp});
        if (mp) push({t, "_redirect"}, redir);
        #1;
        check({31'd0, bus.mispredict});
        if (mp) check(bus.redirect_pc);
    endtask

    task automatic lookup(input string t, input logic [31:0] pc, input logic tk,
                          input logic [31:0] nxt);
        bus.if_pc = pc;
        push({t, "_pred_taken"}, {31'd0, tk});
        push({t, "_pred_next"}, nxt);
        #1;
        check({31'd0, bus.pred_taken});
        check(bus.pred_next_pc);
    endtask

    task automatic cnt_check(input string t, input logic [31:0] bc, input logic [31:0] mc);
        push({t, "_branch_count"}, bc);
        push({t, "_mispredict_count"}, mc);
        #1;
        check(bus.branch_count);
        check(bus.mispredict_count);
    endtask

    initial begin
        idle();
        bus.if_pc = 32'h100;
        reset = 1'b1;
        step();
        reset = 1'b0;

        lookup("reset", 32'h100, 1'b0, 32'h104);
        cnt_check("reset", 0, 0);
        mp_check("reset_idle", 1'b0, 32'h0);

        // first taken branch allocates; same-cycle lookup sees old entry
        resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        mp_check("alloc", 1'b1, 32'h80);
        lookup("same_cycle", 32'h100, 1'b0, 32'h104);
        step();
        lookup("alloc", 32'h100, 1'b1, 32'h80);
        cnt_check("alloc", 1, 1);

        resolve(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
        mp_check("nt1", 1'b1, 32'h104);
        step();
        lookup("nt1", 32'h100, 1'b0, 32'h104);
        cnt_check("nt1", 2, 2);

        resolve(32'h100, 1, 0, 0, 32'h80, 0, 32'h104);
        mp_check("nt2", 1'b0, 32'h0);
        step();
        resolve(32'h100, 1, 0, 0, 32'h80, 0, 32'h104);
        mp_check("nt3", 1'b0, 32'h0);
        step();
        cnt_check("nt3", 4, 2);

        // from ctr=0 one taken must not yet predict taken
        resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        mp_check("tk1", 1'b1, 32'h80);
        step();
        lookup("no_underflow", 32'h100, 1'b0, 32'h104);
        resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        mp_check("tk2", 1'b1, 32'h80);
        step();
        lookup("tk2", 32'h100, 1'b1, 32'h80);

        resolve(32'h100, 1, 0, 1, 32'h80, 1, 32'h80);
        mp_check("tk3", 1'b0, 32'h0);
        step();
        resolve(32'h100, 1, 0, 1, 32'h80, 1, 32'h80);
        mp_check("tk4", 1'b0, 32'h0);
        step();
        resolve(32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
        mp_check("sat_nt", 1'b1, 32'h104);
        step();
        lookup("no_overflow", 32'h100, 1'b1, 32'h80);
        cnt_check("sat", 9, 5);

        // JAL at 0x200 shares index 0 and replaces the 0x100 entry
        resolve(32'h200, 0, 1, 0, 32'h400, 0, 32'h204);
        mp_check("jal_alloc", 1'b1, 32'h400);
        step();
        lookup("jal_alloc", 32'h200, 1'b1, 32'h400);
        lookup("evicted", 32'h100, 1'b0, 32'h104);
        resolve(32'h200, 0, 1, 0, 32'h400, 1, 32'h400);
        mp_check("jal_ok", 1'b0, 32'h0);
        step();
        resolve(32'h200, 0, 1, 0, 32'h400, 1, 32'h300);
        mp_check("jal_badtgt", 1'b1, 32'h400);
        step();
        resolve(32'h200, 0, 1, 0, 32'h500, 1, 32'h400);
        mp_check("jalr_newtgt", 1'b1, 32'h500);
        step();
        lookup("jalr_newtgt", 32'h200, 1'b1, 32'h500);
        cnt_check("jal", 13, 8);

        resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        mp_check("realloc", 1'b1, 32'h80);
        step();
        lookup("realloc", 32'h100, 1'b1, 32'h80);
        lookup("realloc_miss", 32'h200, 1'b0, 32'h204);

        // non-control instruction aliasing into a live entry
        resolve(32'h100, 0, 0, 0, 32'h0, 1, 32'h80);
        mp_check("alias", 1'b1, 32'h104);
        step();
        lookup("alias_inval", 32'h100, 1'b0, 32'h104);
        cnt_check("alias", 14, 10);
        resolve(32'h100, 0, 0, 0, 32'h0, 0, 32'h104);
        mp_check("plain", 1'b0, 32'h0);
        step();

        resolve(32'h180, 1, 0, 1, 32'h40, 0, 32'h184);
        mp_check("conflict", 1'b1, 32'h40);
        step();
        lookup("conflict", 32'h180, 1'b1, 32'h40);
        lookup("conflict_old", 32'h100, 1'b0, 32'h104);

        resolve(32'h300, 1, 0, 0, 32'h900, 0, 32'h304);
        mp_check("miss_nt", 1'b0, 32'h0);
        step();
        lookup("miss_nt_keep", 32'h180, 1'b1, 32'h40);
        lookup("miss_nt_noalloc", 32'h300, 1'b0, 32'h304);

        bus.upd_is_branch = 1'b1;
        bus.upd_taken     = 1'b1;
        bus.upd_pc        = 32'h100;
        bus.upd_target    = 32'h80;
        mp_check("invalid_upd", 1'b0, 32'h0);
        step();
        cnt_check("invalid_upd", 16, 11);

        // reset wins over a coincident update
        reset = 1'b1;
        resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        mp_check("reset_upd", 1'b1, 32'h80);
        step();
        reset = 1'b0;
        lookup("reset_clr", 32'h180, 1'b0, 32'h184);
        lookup("reset_drop", 32'h100, 1'b0, 32'h104);
        cnt_check("reset_clr", 0, 0);

        resolve(32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
        mp_check("post_reset", 1'b1, 32'h80);
        step();
        lookup("post_reset", 32'h100, 1'b1, 32'h80);
        cnt_check("post_reset", 1, 1);

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover observed %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
